// File: rtl/fetch_branch_predictor_if.sv
// Fetch-lookup and resolved-branch-update bundle for fetch_branch_predictor.
// The master drives fetch/update requests; the slave (predictor) returns predictions and flush requests.
interface fetch_branch_predictor_if #(parameter int PC_W = 9);
  logic            fetch_valid;
  logic [PC_W-1:0] fetch_pc;
  logic            pred_ready;
  logic            pred_taken;
  logic [31:0]     pred_target;
  logic            upd_valid;
  logic            upd_ready;
  logic [PC_W-1:0] upd_pc;
  logic            upd_is_branch;
  logic            upd_is_jump;
  logic            upd_is_call;
  logic            upd_is_ret;
  logic            upd_taken;
  logic [31:0]     upd_target;
  logic            upd_pred_taken;
  logic [31:0]     upd_pred_target;
  logic            mispredict;
  logic [31:0]     redirect_pc;

  modport master (
    output fetch_valid, fetch_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
           upd_is_call, upd_is_ret, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_ready, pred_taken, pred_target, upd_ready, mispredict, redirect_pc
  );

  modport slave (
    input  fetch_valid, fetch_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
           upd_is_call, upd_is_ret, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_ready, pred_taken, pred_target, upd_ready, mispredict, redirect_pc
  );
endinterface

// File: rtl/fetch_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch-time prediction, execute-time training, mispredict flush.
// Optional return address stack is built when RAS_EN is defined.
module fetch_branch_predictor #(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fetch_branch_predictor_if.slave bp
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_sweep, w_sweep_next;
  logic             r_mispredict;
  logic [31:0]      r_redirect;

  logic             r_valid  [N];
  logic [1:0]       r_ctr    [N];
  logic [TAG_W-1:0] r_tag    [N];
  logic [31:0]      r_target [N];
  logic             r_jump   [N];

  logic             w_ready;
  logic [IDX_W-1:0] w_f_idx, w_u_idx;
  logic [TAG_W-1:0] w_f_tag, w_u_tag;
  logic             w_f_hit, w_u_hit, w_f_lookup, w_bt_taken, w_ras_hit;
  logic [31:0]      w_fetch_pc4, w_upd_pc4;
  logic             w_accept, w_mis_cond;
  logic [1:0]       w_ctr_new;
  logic             w_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_next;
      r_sweep <= w_sweep_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sweep_next = r_sweep;
    if (r_state == S_INIT) begin
      w_sweep_next = r_sweep + 1'b1;
      if (r_sweep == IDX_W'(N - 1)) w_state_next = S_RUN;
    end
  end

  assign w_ready     = (r_state == S_RUN);
  assign w_f_idx     = bp.fetch_pc[IDX_W+1:2];
  assign w_f_tag     = bp.fetch_pc[PC_W-1:IDX_W+2];
  assign w_u_idx     = bp.upd_pc[IDX_W+1:2];
  assign w_u_tag     = bp.upd_pc[PC_W-1:IDX_W+2];
  assign w_fetch_pc4 = 32'(bp.fetch_pc) + 32'd4;
  assign w_upd_pc4   = 32'(bp.upd_pc) + 32'd4;

  // Arrays are read combinationally, so a same-cycle update is only visible next cycle.
  assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_u_hit    = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_f_lookup = w_ready && bp.fetch_valid && w_f_hit;
  assign w_bt_taken = w_f_lookup && (r_jump[w_f_idx] || r_ctr[w_f_idx][1]);

  assign w_accept   = bp.upd_valid && w_ready;
  assign w_mis_cond = (bp.upd_taken != bp.upd_pred_taken) ||
                      (bp.upd_taken && (bp.upd_target != bp.upd_pred_target));
  assign w_ctr_new  = bp.upd_taken
                      ? ((r_ctr[w_u_idx] == 2'b11) ? 2'b11 : r_ctr[w_u_idx] + 2'b01)
                      : ((r_ctr[w_u_idx] == 2'b00) ? 2'b00 : r_ctr[w_u_idx] - 2'b01);

`ifdef RAS_EN
  logic        r_ret [N];
  logic [31:0] r_ras [4];
  logic [2:0]  r_depth;

  assign w_ras_hit = w_f_lookup && r_ret[w_f_idx] && (r_depth != 3'd0);

  // Slot 0 is the top; a push onto a full stack drops slot 3, the oldest entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_depth <= '0;
      for (int i = 0; i < 4; i++) r_ras[i] <= '0;
    end else if (w_accept && bp.upd_is_call) begin
      for (int i = 3; i > 0; i--) r_ras[i] <= r_ras[i-1];
      r_ras[0] <= w_upd_pc4;
      r_depth  <= (r_depth == 3'd4) ? 3'd4 : r_depth + 3'd1;
    end else if (w_accept && bp.upd_is_ret) begin
      for (int i = 0; i < 3; i++) r_ras[i] <= r_ras[i+1];
      r_ras[3] <= '0;
      r_depth  <= (r_depth == 3'd0) ? 3'd0 : r_depth - 3'd1;
    end
  end

  assign bp.pred_taken  = w_bt_taken || w_ras_hit;
  assign bp.pred_target = w_ras_hit  ? r_ras[0] :
                          w_bt_taken ? r_target[w_f_idx] :
                          w_ready    ? w_fetch_pc4 : 32'd0;
`else
  assign w_ras_hit      = 1'b0;
  assign bp.pred_taken  = w_bt_taken;
  assign bp.pred_target = w_bt_taken ? r_target[w_f_idx] :
                          w_ready    ? w_fetch_pc4 : 32'd0;
`endif

  // Table contents need no reset: the INIT sweep clears every entry before predictions are enabled.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_valid[r_sweep] <= 1'b0;
      r_ctr[r_sweep]   <= 2'b01;
    end else if (w_accept) begin
      if (w_u_hit) begin
        if (bp.upd_is_branch || bp.upd_is_jump) begin
          r_ctr[w_u_idx]  <= w_ctr_new;
          r_jump[w_u_idx] <= bp.upd_is_jump;
          if (bp.upd_taken) r_target[w_u_idx] <= bp.upd_target;
`ifdef RAS_EN
          r_ret[w_u_idx]  <= bp.upd_is_ret;
`endif
        end else begin
          r_valid[w_u_idx] <= 1'b0;
        end
      end else if (bp.upd_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= bp.upd_target;
        r_jump[w_u_idx]   <= bp.upd_is_jump;
        r_ctr[w_u_idx]    <= 2'b10;
`ifdef RAS_EN
        r_ret[w_u_idx]    <= bp.upd_is_ret;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mispredict <= 1'b0;
      r_redirect   <= '0;
    end else begin
      r_mispredict <= w_accept && w_mis_cond;
      if (w_accept && w_mis_cond)
        r_redirect <= bp.upd_taken ? bp.upd_target : w_upd_pc4;
    end
  end

  assign bp.pred_ready  = w_ready;
  assign bp.upd_ready   = w_ready;
  assign bp.mispredict  = r_mispredict;
  assign bp.redirect_pc = r_redirect;

  assign w_unused = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0], bp.upd_is_call, bp.upd_is_ret, w_ras_hit};
endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Directed bench for fetch_branch_predictor: table-level reference model checked every falling edge,
// plus hand-computed literal expectations at key points of the training sequence.
module tb_fetch_branch_predictor;
  localparam int PC_W = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_branch_predictor_if #(.PC_W(PC_W)) bif();
  fetch_branch_predictor #(.PC_W(PC_W), .IDX_W(4)) dut (.clk(clk), .reset_n(reset_n), .bp(bif));

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    bit          j;
    int          ctr;
  } ent_t;

  ent_t        m_tab [16];
  int          m_cnt = 0;
  bit          m_misp = 1'b0;
  logic [31:0] m_redir = 32'd0;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            br, jmp, tk;
    logic [31:0]     tgt;
    logic            ptk;
    logic [31:0]     ptgt;
    logic            e_misp;
    logic [31:0]     e_redir;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [PC_W-1:0] pc);
    return (int'(pc) / 4) % 16;
  endfunction

  function automatic int unsigned tag_of(input logic [PC_W-1:0] pc);
    return int'(pc) / 64;
  endfunction

  function automatic logic [31:0] plus4(input logic [PC_W-1:0] pc);
    logic [31:0] w;
    w = 32'(pc);
    return w + 32'd4;
  endfunction

  // Reference model: 16-entry table, ready after 16 edges out of reset.
  always @(posedge clk or negedge reset_n) begin : model
    int unsigned i;
    bit hit;
    if (!reset_n) begin
      m_cnt = 0;
      m_misp = 1'b0;
      m_redir = 32'd0;
      for (int k = 0; k < 16; k++) m_tab[k].v = 1'b0;
    end else if (m_cnt < 16) begin
      m_cnt++;
      m_misp = 1'b0;
    end else begin
      m_misp = 1'b0;
      if (bif.upd_valid) begin
        i = idx_of(bif.upd_pc);
        hit = m_tab[i].v && (m_tab[i].tag == tag_of(bif.upd_pc));
        if ((bif.upd_taken != bif.upd_pred_taken) ||
            (bif.upd_taken && bif.upd_target != bif.upd_pred_target)) begin
          m_misp = 1'b1;
          m_redir = bif.upd_taken ? bif.upd_target : plus4(bif.upd_pc);
        end
        if (hit && (bif.upd_is_branch || bif.upd_is_jump)) begin
          if (bif.upd_taken) begin
            m_tab[i].ctr = (m_tab[i].ctr >= 3) ? 3 : m_tab[i].ctr + 1;
            m_tab[i].tgt = bif.upd_target;
          end else begin
            m_tab[i].ctr = (m_tab[i].ctr <= 0) ? 0 : m_tab[i].ctr - 1;
          end
          m_tab[i].j = bif.upd_is_jump;
        end else if (hit) begin
          m_tab[i].v = 1'b0;
        end else if (bif.upd_taken) begin
          m_tab[i].v   = 1'b1;
          m_tab[i].tag = tag_of(bif.upd_pc);
          m_tab[i].tgt = bif.upd_target;
          m_tab[i].j   = bif.upd_is_jump;
          m_tab[i].ctr = 2;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ready, hit, tk;
    int unsigned i;
    logic [31:0] tgt;
    ready = reset_n && (m_cnt >= 16);
    i = idx_of(bif.fetch_pc);
    hit = m_tab[i].v && (m_tab[i].tag == tag_of(bif.fetch_pc));
    tk = ready && bif.fetch_valid && hit && (m_tab[i].j || m_tab[i].ctr >= 2);
    tgt = tk ? m_tab[i].tgt : (ready ? plus4(bif.fetch_pc) : 32'd0);
    chk("pred_ready", 32'(bif.pred_ready), 32'(ready));
    chk("upd_ready", 32'(bif.upd_ready), 32'(ready));
    chk("pred_taken", 32'(bif.pred_taken), 32'(tk));
    chk("pred_target", bif.pred_target, tgt);
    chk("mispredict", 32'(bif.mispredict), 32'(m_misp));
    chk("redirect_pc", bif.redirect_pc, m_redir);
  end

  task automatic upd_set(input vec_t v);
    bif.upd_valid       = 1'b1;
    bif.upd_pc          = v.pc;
    bif.upd_is_branch   = v.br;
    bif.upd_is_jump     = v.jmp;
    bif.upd_taken       = v.tk;
    bif.upd_target      = v.tgt;
    bif.upd_pred_taken  = v.ptk;
    bif.upd_pred_target = v.ptgt;
  endtask

  task automatic upd_go(input vec_t v);
    @(posedge clk);
    #1;
    bif.upd_valid = 1'b0;
    $display("upd pc=%h br=%0d jmp=%0d taken=%0d tgt=%h ptk=%0d -> mispredict=%0d redirect=%h",
             v.pc, v.br, v.jmp, v.tk, v.tgt, v.ptk, bif.mispredict, bif.redirect_pc);
    chk("vec_mispredict", 32'(bif.mispredict), 32'(v.e_misp));
    chk("vec_redirect", bif.redirect_pc, v.e_redir);
  endtask

  task automatic upd(input vec_t v);
    upd_set(v);
    upd_go(v);
  endtask

  task automatic fetch_expect(input string name, input logic [PC_W-1:0] pc,
                              input logic tk, input logic [31:0] tgt);
    bif.fetch_pc = pc;
    #1;
    $display("fetch pc=%h -> taken=%0d target=%h", pc, bif.pred_taken, bif.pred_target);
    chk({name, "_taken"}, 32'(bif.pred_taken), 32'(tk));
    chk({name, "_target"}, bif.pred_target, tgt);
  endtask

  vec_t tab_a [5];
  vec_t tab_b [5];
  vec_t v;

  initial begin
    //            pc      br    jmp   tk    tgt     ptk   ptgt    misp  redirect
    tab_a[0] = '{9'h040, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44, 1'b1, 32'h20};
    tab_a[1] = '{9'h040, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h20, 1'b1, 32'h44};
    tab_a[2] = '{9'h040, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h44, 1'b0, 32'h44};
    tab_a[3] = '{9'h040, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h44, 1'b0, 32'h44};
    tab_a[4] = '{9'h040, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44, 1'b1, 32'h20};
    tab_b[0] = '{9'h048, 1'b1, 1'b0, 1'b1, 32'h60, 1'b1, 32'h70, 1'b1, 32'h60};
    tab_b[1] = '{9'h048, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h60, 1'b1, 32'h4C};
    tab_b[2] = '{9'h048, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h4C, 1'b0, 32'h4C};
    tab_b[3] = '{9'h048, 1'b0, 1'b1, 1'b1, 32'h88, 1'b0, 32'h4C, 1'b1, 32'h88};
    tab_b[4] = '{9'h1FC, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h100, 1'b1, 32'h200};

    bif.fetch_valid = 1'b1;
    bif.fetch_pc = 9'h040;
    bif.upd_valid = 1'b0;
    bif.upd_pc = '0;
    bif.upd_is_branch = 1'b0;
    bif.upd_is_jump = 1'b0;
    bif.upd_is_call = 1'b0;
    bif.upd_is_ret = 1'b0;
    bif.upd_taken = 1'b0;
    bif.upd_target = '0;
    bif.upd_pred_taken = 1'b0;
    bif.upd_pred_target = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bif.pred_ready), 32'd0);
    chk("rst_taken", 32'(bif.pred_taken), 32'd0);
    chk("rst_target", bif.pred_target, 32'd0);
    chk("rst_redirect", bif.redirect_pc, 32'd0);

    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      bif.fetch_pc = 9'(c * 4);
      @(posedge clk);
      #1;
    end
    chk("init_ready_at_15", 32'(bif.pred_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("init_ready_at_16", 32'(bif.pred_ready), 32'd1);
    fetch_expect("cold_044", 9'h044, 1'b0, 32'h48);
    fetch_expect("cold_1fc", 9'h1FC, 1'b0, 32'h200);

    // Allocate at 0x40, then walk the counter down to zero and back.
    upd(tab_a[0]);
    fetch_expect("alloc_040", 9'h040, 1'b1, 32'h20);
    @(posedge clk);
    #1;
    chk("misp_one_cycle", 32'(bif.mispredict), 32'd0);
    for (int k = 1; k < 5; k++) begin
      upd(tab_a[k]);
      if (k == 1) fetch_expect("ctr1_040", 9'h040, 1'b0, 32'h44);
    end
    fetch_expect("ctr_sat0_040", 9'h040, 1'b0, 32'h44);

    // Lookup and update on 0x80 in the same cycle: old (miss) result first.
    v = '{9'h080, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h84, 1'b1, 32'h300};
    bif.fetch_pc = 9'h080;
    upd_set(v);
    #1;
    chk("rbw_before_taken", 32'(bif.pred_taken), 32'd0);
    chk("rbw_before_target", bif.pred_target, 32'h84);
    upd_go(v);
    fetch_expect("rbw_after", 9'h080, 1'b1, 32'h300);

    // Jump at 0x100 shares index 0; alias at 0x140 must miss.
    upd('{9'h100, 1'b0, 1'b1, 1'b1, 32'h1C0, 1'b0, 32'h104, 1'b1, 32'h1C0});
    fetch_expect("jump_100", 9'h100, 1'b1, 32'h1C0);
    fetch_expect("alias_140", 9'h140, 1'b0, 32'h144);
    fetch_expect("evicted_080", 9'h080, 1'b0, 32'h84);
    upd('{9'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h1C0});
    fetch_expect("inval_100", 9'h100, 1'b0, 32'h104);

    for (int k = 0; k < 5; k++) upd(tab_b[k]);
    fetch_expect("jumpbit_048", 9'h048, 1'b1, 32'h88);
    fetch_expect("nowrap_1fc", 9'h1FC, 1'b0, 32'h200);
    bif.fetch_valid = 1'b0;
    fetch_expect("novalid_048", 9'h048, 1'b0, 32'h4C);
    bif.fetch_valid = 1'b1;

    // Reset mid-run with a mispredict pending.
    upd('{9'h080, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h84, 1'b1, 32'h10});
    bif.fetch_pc = 9'h080;
    reset_n = 1'b0;
    #1;
    chk("midrst_misp", 32'(bif.mispredict), 32'd0);
    chk("midrst_redirect", bif.redirect_pc, 32'd0);
    chk("midrst_ready", 32'(bif.pred_ready), 32'd0);
    chk("midrst_taken", 32'(bif.pred_taken), 32'd0);
    chk("midrst_target", bif.pred_target, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    upd_set('{9'h1FC, 1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 32'h200, 1'b0, 32'h0});
    for (int c = 0; c < 16; c++) begin
      if (c == 10) bif.upd_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bif.upd_valid = 1'b0;
    chk("reinit_ready", 32'(bif.pred_ready), 32'd1);
    chk("reinit_misp", 32'(bif.mispredict), 32'd0);
    fetch_expect("reinit_080", 9'h080, 1'b0, 32'h84);
    fetch_expect("reinit_048", 9'h048, 1'b0, 32'h4C);
    fetch_expect("dropped_1fc", 9'h1FC, 1'b0, 32'h200);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
